operand_b_issue_stage: RTL

//  ID->EX issue register for the ALU B-operand path. Accepts decoded rs2 data, immediate and
//  B_select from decode and resolves rs2 through EX/WB forwarding. Presents registered

---
 rtl/klp32_pkg.sv | 34 +++
 rtl/issue_skid_buffer.sv | 80 ++++++++
 rtl/operand_b_issue_stage.sv | 88 ++++++++
 3 files changed

// File: rtl/klp32_pkg.sv
// Shared widths, the issue entry layout and the WB snoop helper for the KLP32 ID->EX path.
package klp32_pkg;

    localparam int XLEN    = 32;
    localparam int RADDR_W = 5;

    localparam logic [RADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [XLEN-1:0]    data2;
        logic [XLEN-1:0]    imm;
        logic               b_select;
        logic [RADDR_W-1:0] rs2;
        logic               rs2_used;
    } issue_entry_t;

    localparam int ENTRY_W = $bits(issue_entry_t);

    // A held entry picks up a WB write to its rs2 so it never issues a stale value.
    function automatic issue_entry_t wb_snoop(
        input issue_entry_t       entry,
        input logic               wb_valid,
        input logic [RADDR_W-1:0] wb_rd,
        input logic [XLEN-1:0]    wb_data
    );
        issue_entry_t result;
        result = entry;
        if (wb_valid && (wb_rd != REG_ZERO) && (wb_rd == entry.rs2)) begin
            result.data2 = wb_data;
        end
        return result;
    endfunction

endpackage

// File: rtl/issue_skid_buffer.sv
// Two-entry skid buffer: output always from the main register, registered in_ready.
// Held entries keep the *_hold values supplied by the parent so it can patch them in place.
module issue_skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [WIDTH-1:0] skid_data,
    input  logic [WIDTH-1:0] main_hold,
    input  logic [WIDTH-1:0] skid_hold
);

    logic             main_valid_q, main_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] main_data_q,  main_data_d;
    logic [WIDTH-1:0] skid_data_q,  skid_data_d;
    logic             push;
    logic             pop;

    assign in_ready  = ~skid_valid_q;
    assign out_valid = main_valid_q;
    assign out_data  = main_data_q;
    assign skid_data = skid_data_q;

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path can infer a latch.
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_data_d  = main_hold;
        skid_data_d  = skid_hold;
        push         = in_valid & ~skid_valid_q;
        pop          = main_valid_q & out_ready;

        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (pop) begin
            if (skid_valid_q) begin
                main_data_d  = skid_hold;
                skid_valid_d = 1'b0;
            end else if (push) begin
                main_data_d = in_data;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (push) begin
            if (main_valid_q) begin
                skid_data_d  = in_data;
                skid_valid_d = 1'b1;
            end else begin
                main_data_d  = in_data;
                main_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the data registers are reset too, because the issue outputs must read zero out of reset.
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_data_q  <= '0;
            skid_data_q  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_data_q  <= main_data_d;
            skid_data_q  <= skid_data_d;
        end
    end

endmodule

// File: rtl/operand_b_issue_stage.sv
// ID->EX issue register for the ALU B operand: resolves rs2 through EX/WB forwarding,
// stalls decode on load-use and presents data2/imm/b_select through a 2-entry skid.
module operand_b_issue_stage
    import klp32_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               dec_valid,
    output logic               dec_ready,
    input  logic [XLEN-1:0]    dec_data2,
    input  logic [XLEN-1:0]    dec_imm,
    input  logic               dec_b_select,
    input  logic [RADDR_W-1:0] dec_rs2,
    input  logic               dec_rs2_used,
    input  logic               ex_fwd_valid,
    input  logic [RADDR_W-1:0] ex_fwd_rd,
    input  logic [XLEN-1:0]    ex_fwd_data,
    input  logic               ex_fwd_is_load,
    input  logic               wb_fwd_valid,
    input  logic [RADDR_W-1:0] wb_fwd_rd,
    input  logic [XLEN-1:0]    wb_fwd_data,
    output logic               iss_valid,
    input  logic               iss_ready,
    output logic [XLEN-1:0]    iss_data2,
    output logic [XLEN-1:0]    iss_imm,
    output logic               iss_b_select
);

    logic         rs2_live;
    logic         ex_match;
    logic         wb_match;
    logic         hazard;
    logic         buf_in_ready;
    logic         buf_in_valid;
    issue_entry_t new_entry;
    issue_entry_t main_entry;
    issue_entry_t skid_entry;
    issue_entry_t main_hold;
    issue_entry_t skid_hold;

    assign rs2_live = dec_rs2_used & (dec_rs2 != REG_ZERO);
    assign ex_match = rs2_live & ex_fwd_valid & (ex_fwd_rd == dec_rs2);
    assign wb_match = rs2_live & wb_fwd_valid & (wb_fwd_rd == dec_rs2);
    // Loads stall even when B takes the immediate: stores and branches still need rs2.
    assign hazard   = ex_match & ex_fwd_is_load;

    always_comb begin
        new_entry.imm      = dec_imm;
        new_entry.b_select = dec_b_select;
        new_entry.rs2      = dec_rs2;
        new_entry.rs2_used = dec_rs2_used;
        if (ex_match && !ex_fwd_is_load) begin
            new_entry.data2 = ex_fwd_data;
        end else if (wb_match) begin
            new_entry.data2 = wb_fwd_data;
        end else begin
            new_entry.data2 = dec_data2;
        end
    end

    assign main_hold    = wb_snoop(main_entry, wb_fwd_valid, wb_fwd_rd, wb_fwd_data);
    assign skid_hold    = wb_snoop(skid_entry, wb_fwd_valid, wb_fwd_rd, wb_fwd_data);
    assign buf_in_valid = dec_valid & ~hazard & ~flush;
    assign dec_ready    = buf_in_ready & ~hazard;

    issue_skid_buffer #(
        .WIDTH (ENTRY_W)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (buf_in_valid),
        .in_ready  (buf_in_ready),
        .in_data   (new_entry),
        .out_valid (iss_valid),
        .out_ready (iss_ready),
        .out_data  (main_entry),
        .skid_data (skid_entry),
        .main_hold (main_hold),
        .skid_hold (skid_hold)
    );

    assign iss_data2    = main_entry.data2;
    assign iss_imm      = main_entry.imm;
    assign iss_b_select = main_entry.b_select;

endmodule
